// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register built as a 2-entry in-order skid
// buffer with valid/ready handshakes on both sides, a synchronous flush and
// a forwarding tap taken from the head entry.
//
// Optional feature: define EXMEM_ZERO_FLAG_EN to add the OutZero output,
// a per-entry flag that is set when the accepted ALUResult is zero.
//
// Ports
//   Clk, Reset                   clock, asynchronous active-low reset
//   InValid/InReady              EX-side handshake
//   ALUResult, WriteData, Rd     incoming bundle fields
//   Ctrl                         {RegWrite, MemRead, MemWrite, MemToReg}
//   Flush                        synchronous discard of all held bundles
//   OutValid/OutReady            MEM-side handshake
//   OutALUResult, OutWriteData,
//   OutRd, OutCtrl               head bundle fields
//   FwdRegWrite, FwdRd, FwdData  forwarding tap from the head entry
//   Occupancy                    held bundle count (0..2)
//   OutZero                      head zero flag (EXMEM_ZERO_FLAG_EN only)
module ex_mem_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InValid,
   output logic              InReady,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [REG_W-1:0]  Rd,
   input  logic [3:0]        Ctrl,
   input  logic              Flush,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [DATA_W-1:0] OutALUResult,
   output logic [DATA_W-1:0] OutWriteData,
   output logic [REG_W-1:0]  OutRd,
   output logic [3:0]        OutCtrl,
   output logic              FwdRegWrite,
   output logic [REG_W-1:0]  FwdRd,
   output logic [DATA_W-1:0] FwdData,
`ifdef EXMEM_ZERO_FLAG_EN
   output logic              OutZero,
`endif
   output logic [1:0]        Occupancy
);

   localparam int unsigned DEPTH  = 2;
   localparam int unsigned OCC_W  = 2;
   localparam int unsigned CTRL_W = 4;

   typedef struct packed {
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] wdata;
      logic [REG_W-1:0]  rd;
      logic [CTRL_W-1:0] ctrl;
   } bundle_t;

   // Control state
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;

   // Payload storage; data is left unreset and masked by OutValid
   bundle_t          mem_q [DEPTH];
   bundle_t          in_bundle;
   bundle_t          head;

   logic             push;
   logic             pop;
   logic             out_valid;

   assign in_bundle = '{alu: ALUResult, wdata: WriteData, rd: Rd, ctrl: Ctrl};

   // Ready depends only on registered occupancy, never on OutReady
   assign InReady   = (occ_q < OCC_W'(DEPTH));
   assign out_valid = (occ_q != '0);
   assign push      = InValid && InReady;
   assign pop       = out_valid && OutReady;

   // Control state register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         occ_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         occ_q    <= occ_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Next-state: flush wins over any accept or pop
   always_comb begin
      occ_d    = occ_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (Flush) begin
         occ_d    = '0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   // Payload write at the tail
   always_ff @(posedge Clk) begin
      if (push && !Flush) begin
         mem_q[wr_ptr_q] <= in_bundle;
      end
   end

`ifdef EXMEM_ZERO_FLAG_EN
   logic zero_q [DEPTH];

   // Zero flag stored alongside each bundle
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         zero_q[0] <= 1'b0;
         zero_q[1] <= 1'b0;
      end else if (push && !Flush) begin
         zero_q[wr_ptr_q] <= (ALUResult == '0);
      end
   end

   assign OutZero = out_valid && zero_q[rd_ptr_q];
`endif

   // Head selection uses registered state only
   assign head         = mem_q[rd_ptr_q];
   assign OutValid     = out_valid;
   assign OutALUResult = head.alu;
   assign OutWriteData = head.wdata;
   assign OutRd        = head.rd;
   assign OutCtrl      = out_valid ? head.ctrl : '0;
   assign Occupancy    = occ_q;

   // Forwarding tap mirrors the head entry
   assign FwdRegWrite  = out_valid && head.ctrl[3];
   assign FwdRd        = head.rd;
   assign FwdData      = head.alu;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [4:0]  Rd;
   logic [3:0]  Ctrl;
   logic        Flush;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] OutALUResult;
   logic [31:0] OutWriteData;
   logic [4:0]  OutRd;
   logic [3:0]  OutCtrl;
   logic        FwdRegWrite;
   logic [4:0]  FwdRd;
   logic [31:0] FwdData;
   logic [1:0]  Occupancy;
`ifdef EXMEM_ZERO_FLAG_EN
   logic        OutZero;
`endif

   int checks = 0;
   int errors = 0;

   ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
      .Clk(Clk), .Reset(Reset),
      .InValid(InValid), .InReady(InReady),
      .ALUResult(ALUResult), .WriteData(WriteData), .Rd(Rd), .Ctrl(Ctrl),
      .Flush(Flush),
      .OutValid(OutValid), .OutReady(OutReady),
      .OutALUResult(OutALUResult), .OutWriteData(OutWriteData),
      .OutRd(OutRd), .OutCtrl(OutCtrl),
      .FwdRegWrite(FwdRegWrite), .FwdRd(FwdRd), .FwdData(FwdData),
`ifdef EXMEM_ZERO_FLAG_EN
      .OutZero(OutZero),
`endif
      .Occupancy(Occupancy)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle before sampling/driving
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd, input logic [3:0] c);
      InValid   = v;
      ALUResult = alu;
      WriteData = ~alu;
      Rd        = rd;
      Ctrl      = c;
   endtask

   initial begin
      Reset = 1'b0; Flush = 1'b0; OutReady = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 4'b0000);

      // Reset state with no clock edge yet
      #3;
      check("rst_occ",   32'(Occupancy),   32'd0);
      check("rst_valid", 32'(OutValid),    32'd0);
      check("rst_ctrl",  32'(OutCtrl),     32'd0);
      check("rst_fwdrw", 32'(FwdRegWrite), 32'd0);
      #4 Reset = 1'b1;
      #1;
      check("rst_inready", 32'(InReady), 32'd1);

      // Single bundle, one cycle latency, forwarding tap
      OutReady = 1'b1;
      drive(1'b1, 32'h7, 5'd5, 4'b1000);
      step();
      drive(1'b0, 32'h0, 5'd0, 4'b0000);
      check("lat_valid", 32'(OutValid),    32'd1);
      check("lat_alu",   OutALUResult,     32'h7);
      check("lat_wdata", OutWriteData,     32'hFFFF_FFF8);
      check("lat_ctrl",  32'(OutCtrl),     32'h8);
      check("lat_fwdrw", 32'(FwdRegWrite), 32'd1);
      check("lat_fwdrd", 32'(FwdRd),       32'd5);
      check("lat_fwdd",  FwdData,          32'h7);
      check("lat_occ",   32'(Occupancy),   32'd1);
      step();
      check("pop_valid", 32'(OutValid),    32'd0);
      check("pop_ctrl",  32'(OutCtrl),     32'd0);
      check("pop_fwdrw", 32'(FwdRegWrite), 32'd0);
      // Pop on empty is a no-op
      step();
      check("empty_pop_occ", 32'(Occupancy), 32'd0);

      // Fill to two, third push ignored, drain in order
      OutReady = 1'b0;
      drive(1'b1, 32'h11, 5'd1, 4'b0110);
      step();
      drive(1'b1, 32'h22, 5'd2, 4'b0101);
      step();
      check("full_occ",     32'(Occupancy), 32'd2);
      check("full_inready", 32'(InReady),   32'd0);
      check("full_head",    OutALUResult,   32'h11);
      drive(1'b1, 32'h33, 5'd3, 4'b1111);
      step();
      check("ovf_occ",  32'(Occupancy), 32'd2);
      check("ovf_head", OutALUResult,   32'h11);
      check("ovf_ctrl", 32'(OutCtrl),   32'h6);
      check("ovf_fwdrw", 32'(FwdRegWrite), 32'd0);
      drive(1'b0, 32'h0, 5'd0, 4'b0000);
      OutReady = 1'b1;
      step();
      check("drain1_head", OutALUResult,   32'h22);
      check("drain1_rd",   32'(OutRd),     32'd2);
      check("drain1_occ",  32'(Occupancy), 32'd1);
      step();
      check("drain2_valid", 32'(OutValid),  32'd0);
      check("drain2_occ",   32'(Occupancy), 32'd0);

      // Simultaneous push and pop at occupancy 1
      OutReady = 1'b0;
      drive(1'b1, 32'hAA, 5'd10, 4'b1000);
      step();
      check("sim_pre_head", OutALUResult, 32'hAA);
      drive(1'b1, 32'hBB, 5'd11, 4'b1001);
      OutReady = 1'b1;
      step();
      drive(1'b0, 32'h0, 5'd0, 4'b0000);
      check("sim_occ",  32'(Occupancy), 32'd1);
      check("sim_head", OutALUResult,   32'hBB);
      check("sim_fwdrd", 32'(FwdRd),    32'd11);
      step();
      check("sim_drain_occ", 32'(Occupancy), 32'd0);

      // Flush at full occupancy with an incoming bundle
      OutReady = 1'b0;
      drive(1'b1, 32'h1, 5'd1, 4'b1000);
      step();
      drive(1'b1, 32'h2, 5'd2, 4'b1000);
      step();
      check("pre_flush_occ", 32'(Occupancy), 32'd2);
      OutReady = 1'b1;
      Flush = 1'b1;
      drive(1'b1, 32'h3, 5'd3, 4'b1000);
      step();
      Flush = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 4'b0000);
      check("flush_occ",   32'(Occupancy),   32'd0);
      check("flush_valid", 32'(OutValid),    32'd0);
      check("flush_ctrl",  32'(OutCtrl),     32'd0);
      check("flush_fwdrw", 32'(FwdRegWrite), 32'd0);
      step();
      check("flush_discard_occ", 32'(Occupancy), 32'd0);
      drive(1'b1, 32'h44, 5'd4, 4'b1000);
      step();
      drive(1'b0, 32'h0, 5'd0, 4'b0000);
      check("post_flush_head", OutALUResult, 32'h44);
      step();

      // Asynchronous reset mid-transfer
      OutReady = 1'b0;
      drive(1'b1, 32'h55, 5'd5, 4'b1000);
      step();
      step();
      drive(1'b0, 32'h0, 5'd0, 4'b0000);
      check("pre_rst_occ", 32'(Occupancy), 32'd2);
      #1 Reset = 1'b0;
      #1;
      check("async_rst_occ",   32'(Occupancy), 32'd0);
      check("async_rst_valid", 32'(OutValid),  32'd0);
      check("async_rst_ctrl",  32'(OutCtrl),   32'd0);
      #1 Reset = 1'b1;
      step();
      check("post_rst_inready", 32'(InReady), 32'd1);

`ifdef EXMEM_ZERO_FLAG_EN
      check("zero_empty", 32'(OutZero), 32'd0);
      OutReady = 1'b1;
      drive(1'b1, 32'h0, 5'd1, 4'b1000);
      step();
      check("zero_set", 32'(OutZero), 32'd1);
      drive(1'b1, 32'h1, 5'd2, 4'b1000);
      step();
      drive(1'b0, 32'h0, 5'd0, 4'b0000);
      check("zero_clr", 32'(OutZero), 32'd0);
      step();
      check("zero_masked", 32'(OutZero), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the ALU result and store-data paths.
REQ-002 The block SHALL have parameter REG_W, default 5, meaning the width of the destination register index.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: Clk  input  1  rising-edge clock.
REQ-004 Reset  input  1  asynchronous active-low reset.
REQ-005 InValid  input  1  EX stage presents a valid bundle.
REQ-006 InReady  output  1  stage can accept a bundle this cycle.
REQ-007 ALUResult  input  DATA_W  ALU output from the EX stage.
REQ-008 WriteData  input  DATA_W  rt value for stores.
REQ-009 Rd  input  REG_W  destination register index.
REQ-010 Ctrl  input  4  {RegWrite, MemRead, MemWrite, MemToReg}.
REQ-011 Flush  input  1  synchronous discard of all held bundles.
REQ-012 OutValid  output  1  head bundle valid toward MEM.
REQ-013 OutReady  input  1  MEM accepts the head bundle this cycle.
REQ-014 OutALUResult, OutWriteData, OutRd, OutCtrl  output  DATA_W/DATA_W/REG_W/4  head bundle fields.
REQ-015 FwdRegWrite  output  1; FwdRd  output  REG_W; FwdData  output  DATA_W  forwarding tap from the head entry.
REQ-016 Occupancy  output  2  number of held bundles (0..2).

Function
REQ-017 The block SHALL be a 2-entry in-order skid buffer; a transfer occurs on a rising edge when Valid and Ready are both 1.
REQ-018 InReady SHALL equal (Occupancy < 2), depend only on registered state, and never depend combinationally on OutReady.
REQ-019 Latency SHALL be exactly 1 cycle: a bundle accepted at edge N on an empty stage drives OutValid=1 with its fields after edge N.
REQ-020 Outputs SHALL come from the head entry only; no combinational path from any In* input to any Out*/Fwd* output.
REQ-021 Simultaneous accept and pop SHALL leave Occupancy unchanged and preserve order.
REQ-022 With Occupancy=2, InValid=1 SHALL be ignored (no overwrite, no drop of held data).
REQ-023 Output fields SHALL hold stable while OutValid=1 and OutReady=0.
REQ-024 Flush=1 SHALL set Occupancy to 0 at the next edge, overriding any simultaneous accept or pop; the incoming bundle is discarded.
REQ-025 FwdRegWrite SHALL equal OutValid AND OutCtrl[3]; FwdRd=OutRd; FwdData=OutALUResult.
REQ-026 When OutValid=0, OutCtrl SHALL read 4'b0000 so downstream never sees stale write/memory enables.
REQ-027 Pointers SHALL wrap modulo 2; Occupancy SHALL never exceed 2 or underflow below 0 (pop on empty is a no-op).

Reset
REQ-028 Reset low SHALL immediately, without Clk, force Occupancy=0, OutValid=0, OutCtrl=0, FwdRegWrite=0, InReady=1 once released.
REQ-029 Reset asserted mid-transfer SHALL discard all held bundles; data fields MAY be left unreset but SHALL be masked by OutValid.

Configuration
REQ-030 With macro EXMEM_ZERO_FLAG_EN defined, the block SHALL add output OutZero (1 bit) registered alongside each bundle, equal to 1 when the accepted ALUResult is 0, reset to 0 and forced to 0 when OutValid=0.
REQ-031 Without EXMEM_ZERO_FLAG_EN, the OutZero port and its storage SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset low, Clk idle -> OutValid=0, Occupancy=0, OutCtrl=0 immediately; after release InReady=1.
REQ-033 Empty, OutReady=1, accept ALUResult=0x00000007, Rd=5, Ctrl=4'b1000 -> next cycle OutValid=1, OutALUResult=7, FwdRegWrite=1, FwdRd=5.
REQ-034 OutReady=0, push 0x11 then 0x22 -> Occupancy=2, InReady=0; third push 0x33 ignored; OutReady=1 -> pops 0x11 then 0x22, 0x33 never appears.
REQ-035 Occupancy=1 (0xAA), simultaneous push 0xBB and pop -> Occupancy stays 1, next head 0xBB.
REQ-036 Occupancy=2 plus Flush=1 with InValid=1 -> Occupancy=0, OutValid=0, OutCtrl=0 next cycle.
REQ-037 With EXMEM_ZERO_FLAG_EN, accept ALUResult=0 then 0x1 -> OutZero=1 then 0; without macro, bench compiles without OutZero.
